mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning the number of requesting channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-004 SHALL have parameter MODE, default 1, meaning 0 = fixed priority (ch0 highest) and 1 = round-robin.
REQ-005 SHALL have parameter MAX_WAIT, default 7, meaning the fixed-priority starvation limit in cycles.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port req, input, N_CH, per-channel request.
REQ-009 SHALL have port we, input, N_CH, per-channel write (1) or read (0).
REQ-010 SHALL have port f3, input, 3*N_CH, per-channel load/store funct3, channel i at bits [3i+2:3i].
REQ-011 SHALL have port addr, input, ADDR_W*N_CH, per-channel address.
REQ-012 SHALL have port wdata, input, DATA_W*N_CH, per-channel store data.
REQ-013 SHALL have port gnt, output, N_CH, one-hot grant, combinational in the cycle of acceptance.
REQ-014 SHALL have port rvalid, output, 1, read data valid.
REQ-015 SHALL have port rvalid_id, output, clog2(N_CH), the channel owning rdata.
REQ-016 SHALL have port rdata, output, DATA_W, read data.
REQ-017 SHALL have ports mem_re, mem_we (output, 1), mem_f3 (output, 3), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W), the single memory port command.
REQ-018 SHALL have port mem_rdata, input, DATA_W; memory read data returns one cycle after mem_re.

Function
REQ-019 SHALL grant at most one channel per cycle; gnt SHALL be 0 when req is 0.
REQ-020 SHALL drive the mem_* command from the granted channel in the grant cycle, with mem_re = ~we and mem_we = we; with no grant, mem_re = mem_we = 0 and the other mem_* outputs = 0.
REQ-021 Handshake: a channel SHALL hold req and its payload until it sees gnt; deasserting req before gnt withdraws the request without side effects.
REQ-022 A granted read SHALL produce rvalid = 1 exactly one cycle later, with rvalid_id = granted index and rdata = mem_rdata; otherwise rvalid = 0.
REQ-023 A granted write SHALL produce no rvalid.
REQ-024 MODE 1: a pointer rr_ptr SHALL select the first requester searching from rr_ptr upward, with wrap-around; after a grant to channel k, rr_ptr SHALL become (k+1) mod N_CH, wrapping N_CH-1 to 0; with no grant, rr_ptr SHALL be unchanged.
REQ-025 MODE 0: the lowest-indexed requester SHALL win, except as promoted under REQ-027.
REQ-026 MODE 0: each channel SHALL have a wait counter that increments while req is 1 and gnt is 0, saturates at MAX_WAIT, and clears on grant or when req drops.
REQ-027 MODE 0: a channel whose counter equals MAX_WAIT SHALL win over all others; among several such channels the lowest index wins.
REQ-028 Back-to-back grants SHALL be supported: throughput is one access per cycle, so a read in cycle T and a grant in T+1 overlap.

Reset
REQ-029 While rst = 1 at posedge clk, the block SHALL set rr_ptr = 0, all wait counters = 0, rvalid = 0, rvalid_id = 0 and rdata = 0.
REQ-030 During rst, gnt and mem_re/mem_we SHALL be 0.
REQ-031 A read granted in the cycle before rst SHALL NOT produce rvalid after reset.

Structure
REQ-032 Package riscv_mem_pkg SHALL hold the funct3 constants (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101) and the MODE_FIXED = 0 and MODE_RR = 1 constants.
REQ-033 The priority search SHALL live in one sub-module, rr_priority_pick, taking a request vector and a start index and producing a one-hot winner; it is used by both modes, with start 0 in MODE 0 and the promoted mask applied first.

Verification
REQ-034 MODE 1, N_CH=2: req=11 held for 4 cycles -> gnt = 01, 10, 01, 10.
REQ-035 MODE 1, N_CH=4, rr_ptr=3: req=1001 -> gnt = 1000, then rr_ptr = 0 (wrap).
REQ-036 Read at ch1, addr=0x08, mem_rdata=0xDEADBEEF -> next cycle rvalid=1, rvalid_id=1, rdata=0xDEADBEEF.
REQ-037 MODE 0, MAX_WAIT=3: req=11 held -> ch0 wins cycles 0-2, ch1 wins cycle 3 as promoted, then ch0 wins again.
REQ-038 Write at ch0 with f3=000, wdata=0xAB -> mem_we=1, mem_f3=000, mem_wdata=0xAB, and no rvalid follows.
REQ-039 Read granted, rst asserted the next cycle -> rvalid stays 0, rr_ptr=0 and all counters=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Shared constants for the memory-port arbiter:
//   - RISC-V load/store funct3 encodings carried on the f3/mem_f3 buses
//   - arbitration mode selectors for mem_port_arbiter's MODE parameter
//   - next_idx(): wrap-around successor of a channel index
package riscv_mem_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings (share values with the matching loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Arbitration modes
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Successor of channel k among n channels, wrapping n-1 back to 0.
    function automatic int next_idx(input int k, input int n);
        return (k == n - 1) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick
// Combinational priority search: returns a one-hot vector selecting the
// first set bit of req_i found when scanning upward from start_i, wrapping
// past the top index back to bit 0. All-zero req_i gives an all-zero result.
//
// Ports:
//   req_i    [N-1:0]      request vector
//   start_i  [IDX_W-1:0]  index where the search begins (must be < N)
//   onehot_o [N-1:0]      one-hot winner, zero when no request
module rr_priority_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     onehot_o
);

    logic [N-1:0] wrap_pick;
    logic [N-1:0] fwd_pick;
    logic         fwd_hit;

    // Two candidates are built by a descending scan so that the last write
    // leaves the lowest matching index:
    //   fwd_pick  - lowest requester at or above start_i
    //   wrap_pick - lowest requester overall (used when nothing is at or
    //               above start_i, i.e. the search wrapped around)
    always_comb begin
        wrap_pick = '0;
        fwd_pick  = '0;
        fwd_hit   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                wrap_pick    = '0;
                wrap_pick[i] = 1'b1;
            end
            if (req_i[i] && (IDX_W'(i) >= start_i)) begin
                fwd_pick    = '0;
                fwd_pick[i] = 1'b1;
                fwd_hit     = 1'b1;
            end
        end
        onehot_o = fwd_hit ? fwd_pick : wrap_pick;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between N_CH requesting channels.
// One channel is granted per cycle; its command is forwarded to the memory
// port in the same cycle, and read data returning one cycle later is tagged
// with the owning channel on rvalid/rvalid_id/rdata.
//
// Handshake (req/gnt): a channel raises req with its payload (we, f3, addr,
// wdata) and holds all of them stable until it sees gnt in the same cycle;
// the access is accepted in exactly that cycle. Dropping req before gnt
// withdraws the request with no side effects.
//
// Arbitration:
//   MODE_RR    - round-robin; search starts at rr_ptr, which moves to one past
//                the winner after every grant.
//   MODE_FIXED - channel 0 highest; a channel that has waited MAX_WAIT cycles
//                is promoted above all non-promoted channels.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req/we            per-channel request and write(1)/read(0)
//   f3/addr/wdata     per-channel funct3, byte address, store data (packed)
//   gnt               one-hot grant, combinational, zero during reset
//   rvalid/_id/rdata  read return, one cycle after a granted read
//   mem_*             memory command (mem_rdata returns a cycle after mem_re)
//   dbg_rr_ptr_o      round-robin pointer
//   dbg_wait_cnt_o    per-channel wait counters, channel i at [i*CNT_W +: CNT_W]
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter  int N_CH     = 2,
    parameter  int ADDR_W   = 6,
    parameter  int DATA_W   = 32,
    parameter  int MODE     = 1,
    parameter  int MAX_WAIT = 7,
    localparam int IDX_W    = $clog2(N_CH),
    localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          we,
    input  logic [3*N_CH-1:0]        f3,
    input  logic [ADDR_W*N_CH-1:0]   addr,
    input  logic [DATA_W*N_CH-1:0]   wdata,
    output logic [N_CH-1:0]          gnt,
    output logic                     rvalid,
    output logic [IDX_W-1:0]         rvalid_id,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [2:0]               mem_f3,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [IDX_W-1:0]         dbg_rr_ptr_o,
    output logic [N_CH*CNT_W-1:0]    dbg_wait_cnt_o
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] wait_cnt_q [N_CH];
    logic [CNT_W-1:0] wait_cnt_d [N_CH];
    logic             rvalid_q, rvalid_d;
    logic [IDX_W-1:0] rvalid_id_q, rvalid_id_d;

    logic [N_CH-1:0]  promoted;
    logic [N_CH-1:0]  pick_req;
    logic [IDX_W-1:0] pick_start;
    logic [N_CH-1:0]  pick_gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    always_comb begin
        promoted = '0;
        for (int i = 0; i < N_CH; i++) begin
            promoted[i] = req[i] && (wait_cnt_q[i] == CNT_W'(MAX_WAIT));
        end
    end

    // Fixed priority reuses the round-robin search with start 0; when any
    // channel is starved, only the starved channels enter the search.
    always_comb begin
        if (MODE == MODE_FIXED) begin
            pick_req   = (|promoted) ? promoted : req;
            pick_start = '0;
        end else begin
            pick_req   = req;
            pick_start = rr_ptr_q;
        end
    end

    rr_priority_pick #(
        .N     (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (pick_req),
        .start_i  (pick_start),
        .onehot_o (pick_gnt)
    );

    // Nothing is accepted while reset is held.
    assign gnt     = rst ? '0 : pick_gnt;
    assign gnt_any = |gnt;

    // ------------------------------------------------------------------
    // Memory command mux (zero when idle)
    // ------------------------------------------------------------------
    always_comb begin
        gnt_idx   = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_f3    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                gnt_idx   = IDX_W'(i);
                mem_re    = ~we[i];
                mem_we    = we[i];
                mem_f3    = f3[3*i +: 3];
                mem_addr  = addr[ADDR_W*i +: ADDR_W];
                mem_wdata = wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((MODE == MODE_RR) && gnt_any) begin
            rr_ptr_d = IDX_W'(next_idx(int'(gnt_idx), N_CH));
        end
    end

    // Wait counters only matter for fixed priority; in round-robin they
    // stay at zero.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (MODE == MODE_FIXED) begin
                if (!req[i] || gnt[i]) begin
                    wait_cnt_d[i] = '0;
                end else if (wait_cnt_q[i] != CNT_W'(MAX_WAIT)) begin
                    wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rvalid_d    = mem_re;
    assign rvalid_id_d = gnt_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            rvalid_q    <= 1'b0;
            rvalid_id_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rvalid_q    <= rvalid_d;
            rvalid_id_q <= rvalid_id_d;
            for (int i = 0; i < N_CH; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return
    // ------------------------------------------------------------------
    // A read accepted just before reset would surface during the reset
    // cycle; masking with rst drops it.
    assign rvalid    = rvalid_q & ~rst;
    assign rvalid_id = rvalid_id_q;
    assign rdata     = rvalid ? mem_rdata : '0;

    // ------------------------------------------------------------------
    // Debug visibility
    // ------------------------------------------------------------------
    assign dbg_rr_ptr_o = rr_ptr_q;

    always_comb begin
        dbg_wait_cnt_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            dbg_wait_cnt_o[i*CNT_W +: CNT_W] = wait_cnt_q[i];
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// Two instances share clock and reset:
//   u_rr : N_CH=4, MODE=1 (round-robin), memory model attached
//   u_fp : N_CH=2, MODE=0 (fixed priority), MAX_WAIT=3, writes only
// Stimulus pushes expected grants / read returns into queues; a monitor pops
// and compares whenever a DUT presents gnt or rvalid.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- u_rr signals ----------------
    logic [3:0]   r_req, r_we;
    logic [11:0]  r_f3;
    logic [23:0]  r_addr;
    logic [127:0] r_wdata;
    logic [3:0]   r_gnt;
    logic         r_rvalid;
    logic [1:0]   r_rvalid_id;
    logic [31:0]  r_rdata;
    logic         r_mem_re, r_mem_we;
    logic [2:0]   r_mem_f3;
    logic [5:0]   r_mem_addr;
    logic [31:0]  r_mem_wdata, r_mem_rdata;
    logic [1:0]   r_dbg_ptr;
    logic [11:0]  r_dbg_cnt;

    // ---------------- u_fp signals ----------------
    logic [1:0]   f_req, f_we;
    logic [5:0]   f_f3;
    logic [11:0]  f_addr;
    logic [63:0]  f_wdata;
    logic [1:0]   f_gnt;
    logic         f_rvalid;
    logic [0:0]   f_rvalid_id;
    logic [31:0]  f_rdata;
    logic         f_mem_re, f_mem_we;
    logic [2:0]   f_mem_f3;
    logic [5:0]   f_mem_addr;
    logic [31:0]  f_mem_wdata, f_mem_rdata;
    logic [0:0]   f_dbg_ptr;
    logic [3:0]   f_dbg_cnt;

    mem_port_arbiter #(
        .N_CH(4), .ADDR_W(6), .DATA_W(32), .MODE(1), .MAX_WAIT(7)
    ) u_rr (
        .clk(clk), .rst(rst), .req(r_req), .we(r_we), .f3(r_f3),
        .addr(r_addr), .wdata(r_wdata), .gnt(r_gnt), .rvalid(r_rvalid),
        .rvalid_id(r_rvalid_id), .rdata(r_rdata), .mem_re(r_mem_re),
        .mem_we(r_mem_we), .mem_f3(r_mem_f3), .mem_addr(r_mem_addr),
        .mem_wdata(r_mem_wdata), .mem_rdata(r_mem_rdata),
        .dbg_rr_ptr_o(r_dbg_ptr), .dbg_wait_cnt_o(r_dbg_cnt)
    );

    mem_port_arbiter #(
        .N_CH(2), .ADDR_W(6), .DATA_W(32), .MODE(0), .MAX_WAIT(3)
    ) u_fp (
        .clk(clk), .rst(rst), .req(f_req), .we(f_we), .f3(f_f3),
        .addr(f_addr), .wdata(f_wdata), .gnt(f_gnt), .rvalid(f_rvalid),
        .rvalid_id(f_rvalid_id), .rdata(f_rdata), .mem_re(f_mem_re),
        .mem_we(f_mem_we), .mem_f3(f_mem_f3), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
        .dbg_rr_ptr_o(f_dbg_ptr), .dbg_wait_cnt_o(f_dbg_cnt)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    // {gnt[3:0], re, we, f3[2:0], addr[5:0], wdata[31:0]}
    logic [46:0] exp_q[$];
    // {id[1:0], rdata[31:0]}
    logic [33:0] rv_exp_q[$];
    // {gnt[1:0], addr[5:0]}
    logic [7:0]  fp_exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- u_rr payload ----------------
    logic        ch_we    [4];
    logic [2:0]  ch_f3    [4];
    logic [5:0]  ch_addr  [4];
    logic [31:0] ch_wdata [4];

    task automatic apply_rr();
        for (int i = 0; i < 4; i++) begin
            r_we[i]            = ch_we[i];
            r_f3[3*i +: 3]     = ch_f3[i];
            r_addr[6*i +: 6]   = ch_addr[i];
            r_wdata[32*i +: 32] = ch_wdata[i];
        end
    endtask

    function automatic logic [46:0] rr_rec(input int ch);
        logic [3:0] g;
        g = 4'b0001 << ch;
        return {g, ~ch_we[ch], ch_we[ch], ch_f3[ch], ch_addr[ch], ch_wdata[ch]};
    endfunction

    // Drive u_rr request; gch = expected winner (-1 none), rd = expect read return.
    task automatic drive_rr(input logic [3:0] req_v, input int gch, input logic rd,
                            input logic [31:0] d);
        apply_rr();
        r_req = req_v;
        if (gch >= 0) exp_q.push_back(rr_rec(gch));
        if (rd) rv_exp_q.push_back({2'(gch), d});
    endtask

    task automatic drive_fp(input logic [1:0] req_v, input int gch);
        f_req = req_v;
        if (gch == 0) fp_exp_q.push_back({2'b01, 6'h20});
        if (gch == 1) fp_exp_q.push_back({2'b10, 6'h24});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory model for u_rr ----------------
    logic [31:0] mem_model [16];
    logic        rd_pend;
    logic [5:0]  rd_addr;

    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;
        mem_model[1] = 32'h01010101;
        mem_model[2] = 32'hDEADBEEF;
        mem_model[3] = 32'h0C0C0C0C;
        r_mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            rd_pend = r_mem_re;
            rd_addr = r_mem_addr;
            if (r_mem_we) mem_model[r_mem_addr[5:2]] = r_mem_wdata;
            @(posedge clk);
            #1;
            r_mem_rdata = rd_pend ? mem_model[rd_addr[5:2]] : 32'h0;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (|r_gnt) begin
                if (exp_q.size() == 0)
                    chk("rr_unexpected_gnt", {60'h0, r_gnt}, 64'h0);
                else
                    chk("rr_grant_cmd",
                        {r_gnt, r_mem_re, r_mem_we, r_mem_f3, r_mem_addr, r_mem_wdata},
                        exp_q.pop_front());
            end
            if (r_rvalid) begin
                if (rv_exp_q.size() == 0)
                    chk("rr_unexpected_rvalid", {63'h0, r_rvalid}, 64'h0);
                else
                    chk("rr_read_return", {r_rvalid_id, r_rdata}, rv_exp_q.pop_front());
            end
            if (|f_gnt) begin
                if (fp_exp_q.size() == 0)
                    chk("fp_unexpected_gnt", {62'h0, f_gnt}, 64'h0);
                else
                    chk("fp_grant", {f_gnt, f_mem_addr}, fp_exp_q.pop_front());
            end
            if (f_rvalid) chk("fp_unexpected_rvalid", {63'h0, f_rvalid}, 64'h0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        ch_we[0] = 1'b0; ch_f3[0] = F3_LW;  ch_addr[0] = 6'h04; ch_wdata[0] = 32'hA0A0A0A0;
        ch_we[1] = 1'b0; ch_f3[1] = F3_LW;  ch_addr[1] = 6'h08; ch_wdata[1] = 32'hB1B1B1B1;
        ch_we[2] = 1'b0; ch_f3[2] = F3_LBU; ch_addr[2] = 6'h0C; ch_wdata[2] = 32'hC2C2C2C2;
        ch_we[3] = 1'b1; ch_f3[3] = F3_SW;  ch_addr[3] = 6'h10; ch_wdata[3] = 32'h11223344;
        apply_rr();
        f_we = 2'b11; f_f3 = {F3_SW, F3_SW}; f_addr = {6'h24, 6'h20};
        f_wdata = {32'h0000_2424, 32'h0000_2020}; f_mem_rdata = 32'h0;

        // Reset with every channel requesting: nothing may be granted.
        rst = 1'b1; r_req = 4'b1111; f_req = 2'b11;
        @(negedge clk);
        chk("rst_gnt_zero", {58'h0, r_gnt, f_gnt}, 64'h0);
        chk("rst_mem_re_we_zero", {60'h0, r_mem_re, r_mem_we, f_mem_re, f_mem_we}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; r_req = 4'b0000; f_req = 2'b00;
        @(negedge clk);
        chk("reset_rvalid", {63'h0, r_rvalid}, 64'h0);
        chk("reset_rvalid_id", {62'h0, r_rvalid_id}, 64'h0);
        chk("reset_rdata", {32'h0, r_rdata}, 64'h0);
        chk("reset_rr_ptr", {62'h0, r_dbg_ptr}, 64'h0);
        chk("reset_fp_wait_cnt", {60'h0, f_dbg_cnt}, 64'h0);
        tick();

        // Round-robin alternation, back-to-back reads.
        drive_rr(4'b0011, 0, 1'b1, 32'h01010101); tick();
        drive_rr(4'b0011, 1, 1'b1, 32'hDEADBEEF); tick();
        drive_rr(4'b0011, 0, 1'b1, 32'h01010101); tick();
        drive_rr(4'b0011, 1, 1'b1, 32'hDEADBEEF); tick();
        drive_rr(4'b0100, 2, 1'b1, 32'h0C0C0C0C);
        @(negedge clk); chk("rr_ptr_after_alternation", {62'h0, r_dbg_ptr}, 64'd2); tick();
        // rr_ptr=3, req=1001 -> ch3, pointer wraps to 0.
        drive_rr(4'b1001, 3, 1'b0, 32'h0);
        @(negedge clk); chk("rr_ptr_before_wrap", {62'h0, r_dbg_ptr}, 64'd3); tick();
        drive_rr(4'b1001, 0, 1'b1, 32'h01010101);
        @(negedge clk); chk("rr_ptr_wrapped", {62'h0, r_dbg_ptr}, 64'd0); tick();
        // Idle: no command, pointer holds.
        drive_rr(4'b0000, -1, 1'b0, 32'h0);
        @(negedge clk);
        chk("idle_cmd_zero", {r_gnt, r_mem_re, r_mem_we, r_mem_f3, r_mem_addr, r_mem_wdata}, 64'h0);
        tick();
        drive_rr(4'b0000, -1, 1'b0, 32'h0);
        @(negedge clk);
        chk("idle_rr_ptr_hold", {62'h0, r_dbg_ptr}, 64'd1);
        chk("idle_no_rvalid", {63'h0, r_rvalid}, 64'h0);
        tick();

        // Read ch1 @0x08 returns 0xDEADBEEF next cycle.
        drive_rr(4'b0010, 1, 1'b1, 32'hDEADBEEF); tick();
        drive_rr(4'b0000, -1, 1'b0, 32'h0);
        @(negedge clk);
        chk("read_ch1_return", {29'h0, r_rvalid, r_rvalid_id, r_rdata}, {29'h0, 1'b1, 2'd1, 32'hDEADBEEF});
        tick();

        // Byte store on ch0: write command, no read return.
        ch_we[0] = 1'b1; ch_f3[0] = F3_SB; ch_addr[0] = 6'h14; ch_wdata[0] = 32'h000000AB;
        drive_rr(4'b0001, 0, 1'b0, 32'h0);
        @(negedge clk);
        chk("store_cmd", {r_mem_we, r_mem_re, r_mem_f3, r_mem_wdata}, {29'h0, 1'b1, 1'b0, 3'b000, 32'hAB});
        tick();
        drive_rr(4'b0000, -1, 1'b0, 32'h0);
        @(negedge clk); chk("store_no_rvalid", {63'h0, r_rvalid}, 64'h0); tick();

        // ch2 wins over ch3 (pointer at 1); ch3 then withdraws.
        drive_rr(4'b1100, 2, 1'b1, 32'h0C0C0C0C); tick();
        drive_rr(4'b0000, -1, 1'b0, 32'h0);
        @(negedge clk); chk("withdraw_rr_ptr", {62'h0, r_dbg_ptr}, 64'd3); tick();

        // Read granted, then reset: the return must be dropped.
        drive_rr(4'b0010, 1, 1'b0, 32'h0); tick();
        rst = 1'b1; r_req = 4'b0000;
        @(negedge clk); chk("rst_drops_rvalid", {63'h0, r_rvalid}, 64'h0); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid", {63'h0, r_rvalid}, 64'h0);
        chk("post_rst_rr_ptr", {62'h0, r_dbg_ptr}, 64'd0);
        chk("post_rst_rr_cnt", {52'h0, r_dbg_cnt}, 64'h0);
        tick();

        // Fixed priority with starvation promotion (MAX_WAIT=3).
        drive_fp(2'b11, 0); tick();
        drive_fp(2'b11, 0); tick();
        drive_fp(2'b11, 0); tick();
        drive_fp(2'b11, 1); tick();
        drive_fp(2'b11, 0); tick();
        drive_fp(2'b11, 0); tick();
        drive_fp(2'b00, -1);
        @(negedge clk); chk("fp_ch1_wait_cnt", {62'h0, f_dbg_cnt[3:2]}, 64'd2); tick();
        drive_fp(2'b00, -1);
        @(negedge clk); chk("fp_cnt_clear_on_drop", {62'h0, f_dbg_cnt[3:2]}, 64'd0); tick();
        drive_fp(2'b11, 0); tick();
        drive_fp(2'b11, 0); tick();
        rst = 1'b1; f_req = 2'b11;
        @(negedge clk); chk("fp_rst_gnt_zero", {62'h0, f_gnt}, 64'h0); tick();
        rst = 1'b0;
        drive_fp(2'b11, 0);
        @(negedge clk); chk("fp_post_rst_cnt", {60'h0, f_dbg_cnt}, 64'h0); tick();
        drive_fp(2'b11, 0); tick();
        drive_fp(2'b11, 0); tick();
        drive_fp(2'b11, 1); tick();
        drive_fp(2'b00, -1); tick();
        tick();

        chk("rr_grant_queue_drained", 64'(exp_q.size()), 64'h0);
        chk("rr_read_queue_drained", 64'(rv_exp_q.size()), 64'h0);
        chk("fp_grant_queue_drained", 64'(fp_exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout reached actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
